// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the memory-game pattern transmitter.
// Holds the FSM encoding and the LFSR reset seed / feedback taps.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, GEN, SHOW, DONE} ptx_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/pattern_tx_if.sv
// Control/status bundle between the game FSM (master) and pattern_tx (slave).
// All signals are plain levels or single-cycle pulses; there is no handshake.
interface pattern_tx_if #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               gen_pattern;
    logic [LEN_W-1:0]   len;
    logic               clr;
    logic               seed_load;
    logic [15:0]        seed;
    logic               out_bit;
    logic               out_valid;
    logic               busy;
    logic               done_gen_pattern;
    logic [MAX_LEN-1:0] pattern;

    modport master (
        output gen_pattern, len, clr, seed_load, seed,
        input  out_bit, out_valid, busy, done_gen_pattern, pattern
    );

    modport slave (
        input  gen_pattern, len, clr, seed_load, seed,
        output out_bit, out_valid, busy, done_gen_pattern, pattern
    );
endinterface

// File: rtl/pattern_tx_lfsr16.sv
// 16-bit Galois LFSR; a zero seed is replaced by the default seed.
// Latency: q updates on the edge after step/load; bit_out is q[0] combinationally.
// Backpressure: none, advances only when step is high.
module lfsr16
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] q,
    output logic        bit_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (load) begin
            q <= (seed == 16'h0) ? LFSR_SEED : seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

    assign bit_out = q[0];

endmodule

// File: rtl/pattern_tx.sv
// Generates an L-bit LFSR pattern, plays it MSB first on out_bit, then pulses done.
// Latency: done L + L*(BIT_HOLD+GAP_CYC) edges after the accepting edge (0 for L=0).
// Backpressure: none; gen_pattern while busy is dropped, clr aborts at any time.
module pattern_tx
    import mem_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = $clog2(MAX_LEN + 1),
    parameter int BIT_HOLD = 4,
    parameter int GAP_CYC  = 1
) (
    input  logic         clk,
    input  logic         rst,
    pattern_tx_if.slave  bus
);

    localparam int PER = BIT_HOLD + GAP_CYC;
    localparam int TW  = $clog2(PER + 1);
    localparam int IW  = $clog2(MAX_LEN);

    ptx_state_t         state, state_nxt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_clamp;
    logic [IW-1:0]      idx;
    logic [TW-1:0]      timer;
    logic [MAX_LEN-1:0] pattern_q;
    logic [15:0]        lfsr_q;
    logic               lfsr_bit;
    logic               start;
    logic               bit_end;

    assign len_clamp = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
    assign start     = (state == IDLE) && bus.gen_pattern && !bus.clr;
    assign bit_end   = (timer == TW'(PER - 1));

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .step    ((state == GEN) && !bus.clr),
        .load    ((state == IDLE) && bus.seed_load),
        .seed    (bus.seed),
        .q       (lfsr_q),
        .bit_out (lfsr_bit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (len_clamp == '0) ? DONE : GEN;
            GEN:  if (idx == '0) state_nxt = SHOW;
            SHOW: if (bit_end && idx == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            idx       <= '0;
            timer     <= '0;
            pattern_q <= '0;
        end else begin
            state <= state_nxt;
            if (bus.clr) begin
                idx       <= '0;
                timer     <= '0;
                pattern_q <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        len_q     <= len_clamp;
                        idx       <= IW'(len_clamp - LEN_W'(1));
                        timer     <= '0;
                        pattern_q <= '0;
                    end
                    GEN: begin
                        pattern_q <= {pattern_q[MAX_LEN-2:0], lfsr_bit};
                        // Reload the index so playback starts from the oldest (MSB) bit.
                        idx <= (idx == '0) ? IW'(len_q - LEN_W'(1)) : idx - IW'(1);
                    end
                    SHOW: begin
                        if (bit_end) begin
                            timer <= '0;
                            if (idx != '0) idx <= idx - IW'(1);
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A maximal-length Galois LFSR seeded non-zero can never reach the all-zero state.
    always_ff @(posedge clk) begin
        if (!rst) assert (lfsr_q != 16'h0);
    end

    assign bus.busy             = (state != IDLE);
    assign bus.out_valid        = (state == SHOW) && (timer < TW'(BIT_HOLD));
    assign bus.out_bit          = bus.out_valid && pattern_q[idx];
    assign bus.done_gen_pattern = (state == DONE);
    assign bus.pattern          = pattern_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: per-scenario tasks compare a cycle trace against a
// reference built from the LFSR rule and the hold/gap/latency arithmetic.
module tb_pattern_tx;
    import mem_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int H       = 4;
    localparam int G       = 1;
    localparam int PER     = H + G;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pattern_tx_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

    pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .BIT_HOLD(H), .GAP_CYC(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] m_lfsr;
    logic        obs_v[$], obs_b[$], obs_d[$], obs_busy[$];
    logic [15:0] obs_pat[$], obs_lfsr[$];
    int          err_c;
    logic [3:0]  err_got, err_want;

    function automatic logic [15:0] m_next(input logic [15:0] s);
        logic [15:0] r;
        r = s / 2;
        if (s % 2 == 1) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int clampl(input int l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    // Generated bits shift in at the LSB, so the first one ends up at index L-1.
    function automatic logic [15:0] model_gen(input int l);
        logic [15:0] p = 16'h0;
        for (int k = 0; k < l; k++) begin
            p = (p << 1) | {15'h0, m_lfsr[0]};
            m_lfsr = m_next(m_lfsr);
        end
        return p;
    endfunction

    function automatic int trace_errs(input int l, input logic [15:0] pat);
        int n = 0;
        for (int c = 0; c < obs_v.size(); c++) begin
            logic [3:0] w;
            if (c < l) w = 4'b0001;
            else if (c < l + l * PER) begin
                int k  = (c - l) / PER;
                int ph = (c - l) % PER;
                logic on = (ph < H);
                w = {on, on & pat[l - 1 - k], 1'b0, 1'b1};
            end else if (c == l + l * PER) w = 4'b0011;
            else w = 4'b0000;
            if ({obs_v[c], obs_b[c], obs_d[c], obs_busy[c]} !== w) begin
                if (n == 0) begin
                    err_c    = c;
                    err_got  = {obs_v[c], obs_b[c], obs_d[c], obs_busy[c]};
                    err_want = w;
                end
                n++;
            end
        end
        return n;
    endfunction

    function automatic int done_count();
        int n = 0;
        foreach (obs_d[c]) if (obs_d[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int done_index();
        foreach (obs_d[c]) if (obs_d[c] === 1'b1) return c;
        return -1;
    endfunction

    task automatic idle_inputs();
        bus.gen_pattern = 1'b0;
        bus.len         = '0;
        bus.clr         = 1'b0;
        bus.seed_load   = 1'b0;
        bus.seed        = 16'h0;
    endtask

    // Starts a run and records ncyc cycles of outputs; pa/pb re-pulse gen_pattern,
    // clr_c/rst_c assert clr/rst during that cycle (-1 = never).
    task automatic play(input int lreq, input int ncyc, input int pa, input int pb,
                        input int clr_c, input int rst_c, input bit with_seed,
                        input logic [15:0] sd);
        obs_v.delete(); obs_b.delete(); obs_d.delete(); obs_busy.delete();
        obs_pat.delete(); obs_lfsr.delete();
        bus.gen_pattern = 1'b1;
        bus.len         = LEN_W'(lreq);
        bus.seed_load   = with_seed;
        bus.seed        = sd;
        @(posedge clk); #1;
        idle_inputs();
        for (int c = 0; c < ncyc; c++) begin
            bus.gen_pattern = (c == pa) || (c == pb);
            bus.len         = LEN_W'($urandom_range(1, 16));
            bus.clr         = (c == clr_c);
            rst             = (c == rst_c);
            @(negedge clk);
            obs_v.push_back(bus.out_valid);
            obs_b.push_back(bus.out_bit);
            obs_d.push_back(bus.done_gen_pattern);
            obs_busy.push_back(bus.busy);
            obs_pat.push_back(bus.pattern);
            obs_lfsr.push_back(dut.u_lfsr.q);
            @(posedge clk); #1;
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus.out_valid, bus.out_bit, bus.busy, bus.done_gen_pattern} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 0000",
                     {bus.out_valid, bus.out_bit, bus.busy, bus.done_gen_pattern});
        end
        tests++;
        if (bus.pattern !== 16'h0) begin
            fails++; $display("FAIL reset_pattern: got %h want 0000", bus.pattern);
        end
        tests++;
        if (dut.u_lfsr.q !== 16'hACE1) begin
            fails++; $display("FAIL reset_lfsr: got %h want ace1", dut.u_lfsr.q);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input string nm, input logic [15:0] want_pat);
        logic [15:0] exp;
        int n;
        exp = model_gen(5);
        play(5, 32, -1, -1, -1, -1, 1'b0, 16'h0);
        tests++;
        if (obs_pat[31] !== exp || exp !== want_pat) begin
            fails++;
            $display("FAIL %s_pattern: got %h model %h want %h", nm, obs_pat[31], exp, want_pat);
        end
        n = trace_errs(5, exp);
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL %s_trace: %0d bad cycles, first %0d got vbdy=%b want %b",
                     nm, n, err_c, err_got, err_want);
        end
        tests++;
        if (done_index() != 30 || done_count() != 1) begin
            fails++;
            $display("FAIL %s_done: got index %0d count %0d want 30 and 1",
                     nm, done_index(), done_count());
        end
        tests++;
        if (obs_lfsr[31] !== m_lfsr) begin
            fails++; $display("FAIL %s_lfsr: got %h want %h", nm, obs_lfsr[31], m_lfsr);
        end
    endtask

    task automatic test_len_edges();
        logic [15:0] exp;
        int n;
        play(0, 3, -1, -1, -1, -1, 1'b0, 16'h0);
        n = trace_errs(0, 16'h0);
        tests++;
        if (n != 0 || obs_pat[2] !== 16'h0) begin
            fails++;
            $display("FAIL len0: %0d bad cycles (first %0d got %b want %b), pattern %h want 0000",
                     n, err_c, err_got, err_want, obs_pat[2]);
        end
        exp = model_gen(clampl(20));
        play(20, 98, -1, -1, -1, -1, 1'b0, 16'h0);
        n = trace_errs(16, exp);
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL clamp_trace: %0d bad cycles, first %0d got %b want %b",
                     n, err_c, err_got, err_want);
        end
        tests++;
        if (done_index() != 96 || obs_pat[97] !== exp) begin
            fails++;
            $display("FAIL clamp_done: done at %0d want 96, pattern %h want %h",
                     done_index(), obs_pat[97], exp);
        end
    endtask

    task automatic test_clr();
        logic [15:0] exp;
        exp = model_gen(5);
        // Bit index 2 of 5 is shown from cycle 5 + 2*PER = 15; abort during its hold.
        play(5, 25, -1, -1, 16, -1, 1'b0, 16'h0);
        tests++;
        if (obs_v[16] !== 1'b1 || obs_b[16] !== exp[2]) begin
            fails++;
            $display("FAIL clr_before: got valid %b bit %b want 1 %b", obs_v[16], obs_b[16], exp[2]);
        end
        tests++;
        if ({obs_v[17], obs_b[17], obs_busy[17]} !== 3'b000 || obs_pat[17] !== 16'h0
            || done_count() != 0) begin
            fails++;
            $display("FAIL clr_after: got vbb=%b pattern %h dones %0d want 000 0000 0",
                     {obs_v[17], obs_b[17], obs_busy[17]}, obs_pat[17], done_count());
        end
        tests++;
        if (obs_lfsr[24] !== m_lfsr) begin
            fails++; $display("FAIL clr_lfsr: got %h want %h", obs_lfsr[24], m_lfsr);
        end
        exp = model_gen(5);
        play(5, 32, -1, -1, -1, -1, 1'b0, 16'h0);
        tests++;
        if (obs_pat[31] !== exp || trace_errs(5, exp) != 0) begin
            fails++;
            $display("FAIL clr_restart: got pattern %h want %h, bad cycles %0d",
                     obs_pat[31], exp, trace_errs(5, exp));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        exp = model_gen(5);
        play(5, 32, 2, 12, -1, -1, 1'b0, 16'h0);
        tests++;
        if (trace_errs(5, exp) != 0 || done_count() != 1 || obs_pat[31] !== exp) begin
            fails++;
            $display("FAIL repulse: bad cycles %0d dones %0d want 1, pattern %h want %h",
                     trace_errs(5, exp), done_count(), obs_pat[31], exp);
        end
    endtask

    task automatic test_seed_zero();
        bus.seed_load = 1'b1;
        bus.seed      = 16'h0;
        @(posedge clk); #1;
        idle_inputs();
        m_lfsr = 16'hACE1;
        @(negedge clk);
        tests++;
        if (dut.u_lfsr.q !== 16'hACE1) begin
            fails++; $display("FAIL seed0_lfsr: got %h want ace1", dut.u_lfsr.q);
        end
        @(posedge clk); #1;
        test_basic("seed0", 16'h0010);
    endtask

    task automatic test_rst_mid();
        play(5, 16, -1, -1, -1, 12, 1'b0, 16'h0);
        m_lfsr = 16'hACE1;
        tests++;
        if ({obs_v[13], obs_b[13], obs_busy[13], obs_d[13]} !== 4'b0000 || obs_pat[13] !== 16'h0
            || obs_lfsr[13] !== 16'hACE1) begin
            fails++;
            $display("FAIL rst_mid: got vbbd=%b pattern %h lfsr %h want 0000 0000 ace1",
                     {obs_v[13], obs_b[13], obs_busy[13], obs_d[13]}, obs_pat[13], obs_lfsr[13]);
        end
        tests++;
        if (obs_v[12] !== 1'b1) begin
            fails++; $display("FAIL rst_mid_showing: got valid %b want 1", obs_v[12]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int lreq, l, n;
            logic [15:0] sd, exp;
            lreq = (it == 5) ? $urandom_range(17, 31) : $urandom_range(1, 16);
            l    = clampl(lreq);
            sd   = (it == 2) ? 16'h0 : 16'($urandom);
            m_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
            exp  = model_gen(l);
            play(lreq, l + l * PER + 2, -1, -1, -1, -1, 1'b1, sd);
            n = trace_errs(l, exp);
            tests++;
            if (n != 0 || obs_pat[l + l * PER + 1] !== exp || obs_lfsr[l + l * PER + 1] !== m_lfsr) begin
                fails++;
                $display("FAIL random_%0d: len %0d seed %h bad cycles %0d, pattern %h want %h, lfsr %h want %h",
                         it, lreq, sd, n, obs_pat[l + l * PER + 1], exp,
                         obs_lfsr[l + l * PER + 1], m_lfsr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic("first", 16'h0010);
        tests++;
        if (obs_lfsr[31] !== 16'h0E27) begin
            fails++; $display("FAIL first_lfsr_const: got %h want 0e27", obs_lfsr[31]);
        end
        test_basic("second", 16'h001C);
        test_len_edges();
        test_clr();
        test_back_to_back();
        test_seed_zero();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
